// File: rtl/ysyx_22040228_lsu_pkg.sv
// ysyx_22040228_lsu_pkg: size encodings, FSM states and helpers shared by the load/store unit.
package ysyx_22040228_lsu_pkg;
   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam logic [1:0] SZ_D = 2'b11;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ0  = 3'd1,
      WAIT0 = 3'd2,
      REQ1  = 3'd3,
      WAIT1 = 3'd4,
      RESP  = 3'd5
   } state_t;

   function automatic logic [3:0] bytes_of(input logic [1:0] size);
      return 4'(1) << size;
   endfunction
endpackage

// File: rtl/ysyx_22040228_lsu_align.sv
// ysyx_22040228_lsu_align: store lane steering and load merge/shift/extend over a two-word window.
module ysyx_22040228_lsu_align
   import ysyx_22040228_lsu_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [1:0]                  size,
   input  logic                        uns,
   input  logic [$clog2(XLEN/8)-1:0]   off,
   input  logic [XLEN-1:0]             wdata,
   input  logic [XLEN-1:0]             buf0,
   input  logic [XLEN-1:0]             buf1,
   output logic [XLEN-1:0]             w_lo,
   output logic [XLEN-1:0]             w_hi,
   output logic [XLEN/8-1:0]           m_lo,
   output logic [XLEN/8-1:0]           m_hi,
   output logic [XLEN-1:0]             ld
);
   localparam int NB = XLEN / 8;
   logic [3:0]          nbytes;
   logic [XLEN-1:0]     dmask, raw;
   logic [2*XLEN-1:0]   wwin, rwin;
   logic [2*NB-1:0]     mwin;
   logic                sign;
   assign nbytes = bytes_of(size);
   // all-ones for a full-width access because the shift runs off the top
   assign dmask  = ~({XLEN{1'b1}} << {nbytes, 3'b000});
   assign wwin   = {{XLEN{1'b0}}, wdata & dmask} << {off, 3'b000};
   assign mwin   = (((2*NB)'(1) << nbytes) - (2*NB)'(1)) << off;
   assign w_lo   = wwin[XLEN-1:0];
   assign w_hi   = wwin[2*XLEN-1:XLEN];
   assign m_lo   = mwin[NB-1:0];
   assign m_hi   = mwin[2*NB-1:NB];
   assign rwin   = {buf1, buf0} >> {off, 3'b000};
   assign raw    = rwin[XLEN-1:0];
   assign sign   = size == SZ_B ? raw[7] : size == SZ_H ? raw[15] : raw[31];
   assign ld     = (raw & dmask) | ((uns || !sign) ? '0 : ~dmask);
endmodule

// File: rtl/ysyx_22040228_lsu_seq.sv
// ysyx_22040228_lsu_seq: MEM-stage load/store unit; bus request/response FSM that splits
// word-straddling accesses into two beats and extends load data for write-back.
module ysyx_22040228_lsu_seq
   import ysyx_22040228_lsu_pkg::*;
#(
   parameter int XLEN           = 64,
   parameter bit ALLOW_MISALIGN = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [1:0]          req_size,
   input  logic                req_unsigned,
   input  logic [XLEN-1:0]     req_addr,
   input  logic [XLEN-1:0]     req_wdata,
   input  logic [4:0]          req_rd,
   output logic                bus_valid,
   input  logic                bus_ready,
   output logic                bus_we,
   output logic [XLEN-1:0]     bus_addr,
   output logic [XLEN-1:0]     bus_wdata,
   output logic [XLEN/8-1:0]   bus_wmask,
   input  logic                bus_rvalid,
   input  logic [XLEN-1:0]     bus_rdata,
   output logic                rsp_valid,
   output logic [XLEN-1:0]     rsp_rdata,
   output logic [4:0]          rsp_rd,
   output logic                rsp_err,
   output logic                stall
);
   localparam int NB   = XLEN / 8;
   localparam int OFFW = $clog2(NB);
   state_t              state;
   logic                we, uns, split, err;
   logic [1:0]          size;
   logic [XLEN-1:0]     addr, wdata, buf0, buf1, base, w_lo, w_hi, ld;
   logic [4:0]          rd;
   logic [NB-1:0]       m_lo, m_hi;
   logic [3:0]          req_bytes;
   logic [OFFW-1:0]     req_off;
   logic                req_split, req_bad;
   assign req_bytes = bytes_of(req_size);
   assign req_off   = req_addr[OFFW-1:0];
   assign req_split = 5'(req_off) + 5'(req_bytes) > 5'(NB);
   assign req_bad   = (XLEN == 32 && req_size == SZ_D) ||
                      (!ALLOW_MISALIGN && (req_off & (OFFW'(req_bytes) - OFFW'(1))) != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         we    <= 1'b0;
         uns   <= 1'b0;
         split <= 1'b0;
         err   <= 1'b0;
         size  <= '0;
         addr  <= '0;
         wdata <= '0;
         rd    <= '0;
         buf0  <= '0;
         buf1  <= '0;
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               we    <= req_we;
               uns   <= req_unsigned;
               size  <= req_size;
               addr  <= req_addr;
               wdata <= req_wdata;
               rd    <= req_rd;
               split <= req_split;
               err   <= req_bad;
               state <= req_bad ? RESP : REQ0;
            end
            REQ0:  if (bus_ready) state <= WAIT0;
            WAIT0: if (bus_rvalid) begin
               buf0  <= bus_rdata;
               state <= split ? REQ1 : RESP;
            end
            REQ1:  if (bus_ready) state <= WAIT1;
            WAIT1: if (bus_rvalid) begin
               buf1  <= bus_rdata;
               state <= RESP;
            end
            default: state <= IDLE;
         endcase
      end
   end

   ysyx_22040228_lsu_align #(.XLEN(XLEN)) u_align (
      .size  (size),
      .uns   (uns),
      .off   (addr[OFFW-1:0]),
      .wdata (wdata),
      .buf0  (buf0),
      .buf1  (buf1),
      .w_lo  (w_lo),
      .w_hi  (w_hi),
      .m_lo  (m_lo),
      .m_hi  (m_hi),
      .ld    (ld)
   );

   // bus fields are decoded from captured request state, so they stay stable while bus_ready is low
   assign base      = {addr[XLEN-1:OFFW], {OFFW{1'b0}}};
   assign req_ready = state == IDLE;
   assign bus_valid = state == REQ0 || state == REQ1;
   assign bus_we    = bus_valid && we;
   assign bus_addr  = bus_valid ? base + (state == REQ1 ? XLEN'(NB) : '0) : '0;
   assign bus_wdata = bus_we ? (state == REQ1 ? w_hi : w_lo) : '0;
   assign bus_wmask = bus_valid ? (state == REQ1 ? m_hi : m_lo) : '0;
   assign rsp_valid = state == RESP;
   assign rsp_err   = rsp_valid && err;
   assign rsp_rdata = (rsp_valid && !we && !err) ? ld : '0;
   assign rsp_rd    = rd;
   assign stall     = !req_ready && !rsp_valid;
endmodule
